// File: rtl/fetch_stage.sv
// Instruction fetch stage: a single-outstanding-request fetcher with a one-entry
// skid buffer that parks data while decode stalls. It also flushes on a redirect.
module fetch_stage #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h8000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [3:0]         if_opcode
);

  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HOLD} state_t;

  state_t               state, state_d;
  logic [PC_W-1:0]      pc, pc_d;
  logic [PC_W-1:0]      drain_addr, drain_addr_d;
  logic                 valid_d;
  logic [INSTR_W-1:0]   instr_d;
  logic [PC_W-1:0]      if_pc_d;
  logic                 buf_valid, buf_valid_d;
  logic [INSTR_W-1:0]   buf_instr, buf_instr_d;
  logic [PC_W-1:0]      buf_pc, buf_pc_d;
  logic                 post_rst;
  logic                 load;
  logic                 ack_ok;

  assign load      = !stall || !if_valid;
  // An ack arriving in the first cycle after reset belongs to an abandoned access.
  assign ack_ok    = imem_ack && !post_rst;
  assign imem_req  = !rst && (state != S_HOLD);
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
  assign if_opcode = if_instr[INSTR_W-1 -: 4];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d      = state;
    pc_d         = pc;
    drain_addr_d = drain_addr;
    valid_d      = if_valid;
    instr_d      = if_instr;
    if_pc_d      = if_pc;
    buf_valid_d  = buf_valid;
    buf_instr_d  = buf_instr;
    buf_pc_d     = buf_pc;

    if (redirect_valid) begin
      valid_d     = 1'b0;
      instr_d     = NOP_INSTR;
      buf_valid_d = 1'b0;
      pc_d        = redirect_pc;
      unique case (state)
        S_FETCH: if (!ack_ok) begin
          // The old request is still in flight; its ack must be swallowed.
          state_d      = S_DRAIN;
          drain_addr_d = pc;
        end
        S_DRAIN: if (imem_ack) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ack_ok) begin
            pc_d = pc + PC_W'(1);
            if (load) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              if_pc_d = pc;
            end else begin
              buf_valid_d = 1'b1;
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc;
              state_d     = S_HOLD;
            end
          end else if (load) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state_d = S_FETCH;
          if (load) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        default: begin
          if (load) begin
            valid_d     = 1'b1;
            instr_d     = buf_instr;
            if_pc_d     = buf_pc;
            buf_valid_d = 1'b0;
            state_d     = S_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      drain_addr <= '0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
      buf_valid  <= 1'b0;
      post_rst   <= 1'b1;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      drain_addr <= drain_addr_d;
      if_valid   <= valid_d;
      if_instr   <= instr_d;
      if_pc      <= if_pc_d;
      buf_valid  <= buf_valid_d;
      post_rst   <= 1'b0;
    end
  end

  // NOTE: skid payload is not reset; buf_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    buf_instr <= buf_instr_d;
    buf_pc    <= buf_pc_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a single-cycle memory model feeds a
// scoreboard of accepted fetches, which is checked whenever decode consumes an instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic [3:0]  if_opcode;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic tb_first     = 1'b0;
  logic tb_drain     = 1'b0;
  logic       pre_req;
  logic [7:0] pre_addr;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock cycle: drive controls, answer the request, update the scoreboard.
  task automatic cycle(input logic c_rst, input logic c_stall, input logic c_redir,
                       input logic [7:0] c_rpc, input logic c_ack_en);
    exp_t e;
    @(negedge clk);
    rst            = c_rst;
    stall          = c_stall;
    redirect_valid = c_redir;
    redirect_pc    = c_rpc;
    #1;
    pre_req    = imem_req;
    pre_addr   = imem_addr;
    imem_ack   = c_ack_en && imem_req;
    imem_rdata = 16'h1000 + {8'h00, imem_addr};
    if (!c_rst && if_valid && !c_stall) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_consume: got pc=%h instr=%h, required no instruction", if_pc, if_instr);
      end else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          tests_failed++;
          $display("FAIL sb_consume: got pc=%h instr=%h, required pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    if (c_rst || c_redir) sb.delete();
    else if (imem_ack && !tb_first && !tb_drain) sb.push_back('{imem_addr, imem_rdata});
    if (c_rst) begin
      tb_first = 1'b1;
      tb_drain = 1'b0;
    end else begin
      if (tb_drain) begin
        if (imem_ack) tb_drain = 1'b0;
      end else if (c_redir && imem_req && !(imem_ack && !tb_first)) begin
        tb_drain = 1'b1;
      end
      tb_first = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 1, 1, 8'h33, 1);
    tests_run++;
    if (if_valid !== 1'b0 || if_instr !== 16'h8000 || if_pc !== 8'h00 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b instr=%h pc=%h req=%b, required 0 8000 00 0",
               if_valid, if_instr, if_pc, imem_req);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (pre_req !== 1'b1 || pre_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_release: got req=%b addr=%h, required 1 00", pre_req, pre_addr);
    end
    tests_run++;
    if (if_valid !== 1'b0 || imem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_late_ack: got v=%b addr=%h, required 0 00", if_valid, imem_addr);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 8'h00, 1);
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'(i) || if_instr !== 16'h1000 + 16'(i) || if_opcode !== 4'h1) begin
        tests_failed++;
        $display("FAIL stream_%0d: got v=%b pc=%h instr=%h op=%h, required 1 %h %h 1",
                 i, if_valid, if_pc, if_instr, if_opcode, 8'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 8'h00, 1);
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'h05 || if_instr !== 16'h1005 || imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h req=%b, required 1 05 1005 0",
                 i, if_valid, if_pc, if_instr, imem_req);
      end
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (pre_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 8'h06 || if_instr !== 16'h1006) begin
      tests_failed++;
      $display("FAIL stall_release: got req=%b v=%b pc=%h instr=%h, required 0 1 06 1006",
               pre_req, if_valid, if_pc, if_instr);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (pre_addr !== 8'h07 || if_pc !== 8'h07) begin
      tests_failed++;
      $display("FAIL stall_resume: got addr=%h pc=%h, required 07 07", pre_addr, if_pc);
    end
  endtask

  task automatic test_redirect_drain;
    cycle(1, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 8'h40, 0);
    tests_run++;
    if (pre_addr !== 8'h05 || if_valid !== 1'b0 || if_instr !== 16'h8000 || imem_addr !== 8'h05) begin
      tests_failed++;
      $display("FAIL drain_enter: got pre=%h v=%b instr=%h addr=%h, required 05 0 8000 05",
               pre_addr, if_valid, if_instr, imem_addr);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (pre_addr !== 8'h05 || if_valid !== 1'b0 || if_instr !== 16'h8000 || imem_addr !== 8'h40) begin
      tests_failed++;
      $display("FAIL drain_discard: got pre=%h v=%b instr=%h addr=%h, required 05 0 8000 40",
               pre_addr, if_valid, if_instr, imem_addr);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h40 || if_instr !== 16'h1040) begin
      tests_failed++;
      $display("FAIL drain_target: got v=%b pc=%h instr=%h, required 1 40 1040", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_ack_redirect;
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 1, 8'h80, 1);
    tests_run++;
    if (pre_addr !== 8'h42 || if_valid !== 1'b0 || imem_addr !== 8'h80) begin
      tests_failed++;
      $display("FAIL ackredir_flush: got pre=%h v=%b addr=%h, required 42 0 80", pre_addr, if_valid, imem_addr);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h80 || if_instr !== 16'h1080) begin
      tests_failed++;
      $display("FAIL ackredir_target: got v=%b pc=%h instr=%h, required 1 80 1080", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap;
    cycle(0, 0, 1, 8'hFE, 1);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (if_pc !== 8'hFF || if_instr !== 16'h10FF || imem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL wrap_ff: got pc=%h instr=%h addr=%h, required FF 10FF 00", if_pc, if_instr, imem_addr);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'h1000) begin
      tests_failed++;
      $display("FAIL wrap_00: got v=%b pc=%h instr=%h, required 1 00 1000", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_in_hold;
    cycle(0, 1, 0, 8'h00, 1);
    tests_run++;
    if (imem_req !== 1'b0 || if_pc !== 8'h00) begin
      tests_failed++;
      $display("FAIL rsthold_enter: got req=%b pc=%h, required 0 00", imem_req, if_pc);
    end
    cycle(1, 1, 0, 8'h00, 0);
    tests_run++;
    if (if_valid !== 1'b0 || if_instr !== 16'h8000 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsthold_reset: got v=%b instr=%h req=%b, required 0 8000 0", if_valid, if_instr, imem_req);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (pre_req !== 1'b1 || pre_addr !== 8'h00 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsthold_release: got req=%b addr=%h v=%b, required 1 00 0", pre_req, pre_addr, if_valid);
    end
    cycle(0, 0, 0, 8'h00, 1);
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'h1000) begin
      tests_failed++;
      $display("FAIL rsthold_first: got v=%b pc=%h instr=%h, required 1 00 1000", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_final_drain;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 0);
    tests_run++;
    if (sb.size() != 0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL sb_empty: got %0d pending v=%b, required 0 pending v=0", sb.size(), if_valid);
    end
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    imem_ack       = 1'b0;
    imem_rdata     = 16'h0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_ack_redirect();
    test_wrap();
    test_reset_in_hold();
    test_final_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
